cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Shares the single burst-mode physical memory port between the instruction cache and the data cache of the pipelined RV32I core, and converts each granted 256-bit cacheline transfer into four 64-bit memory bursts. It sits between the two caches and the burst memory model (latency-parameterised memory) in the CPU top level. It fairly alternates between requesters under contention and returns a single-cycle response to the granted cache.

## Interface
- LINE_WIDTH, 256, cacheline width in bits
- BURST_WIDTH, 64, memory data beat width in bits
- ADDR_WIDTH, 32, byte address width
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_addr  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache, valid when i_resp
- i_resp  out  1  I-cache transaction done, one-cycle pulse
- d_read  in  1  D-cache line read request, level, held until d_resp
- d_write  in  1  D-cache line write-back request, level, held until d_resp
- d_addr  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  write-back line
- d_rdata  out  LINE_WIDTH  line returned to D-cache, valid when d_resp
- d_resp  out  1  D-cache transaction done, one-cycle pulse
- pmem_read  out  1  burst read, held for the whole 4-beat transaction
- pmem_write  out  1  burst write, held for the whole 4-beat transaction
- pmem_addr  out  ADDR_WIDTH  line-aligned address, constant during a transaction
- pmem_wdata  out  BURST_WIDTH  current write beat
- pmem_rdata  in  BURST_WIDTH  current read beat, valid when pmem_resp
- pmem_resp  in  1  one beat accepted/returned

## Operation
- BEATS = LINE_WIDTH/BURST_WIDTH = 4; 2-bit beat counter.
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE: sample requests; pick winner; latch address with low log2(LINE_WIDTH/8)=5 bits cleared; for D_WR latch d_wdata into line buffer; counter := 0.
- Arbitration: round-robin via one-bit priority pointer, reset value = D. With both sides requesting, pointer side wins; after any grant pointer moves to the other side. Single requester always wins.
- d_read and d_write both high: d_write wins (D_WR).
- I_RD/D_RD: pmem_read=1; on pmem_resp, beat[counter] := pmem_rdata (beat 0 = bits 63:0), counter++; on 4th resp go DONE.
- D_WR: pmem_write=1; pmem_wdata = buffer beat[counter]; on pmem_resp counter++; on 4th resp go DONE.
- DONE: assert i_resp or d_resp (granted side) for exactly one cycle, line buffer on i_rdata/d_rdata; next state IDLE unconditionally. Requester drops request in the cycle after resp; IDLE re-samples only then, so no double grant.
- pmem_resp in IDLE or DONE ignored. Request inputs ignored outside IDLE; a held request waits.
- i_rdata and d_rdata both driven from the same line buffer; contents meaningful only with resp.

## Timing
- All outputs registered or decoded from state register; no input-to-output combinational path.
- Reset (rst=0, async): state IDLE, counter 0, pointer D, buffer 0, address 0; pmem_read, pmem_write, i_resp, d_resp = 0 immediately, i_rdata/d_rdata/pmem_wdata = 0. Reset mid-transaction aborts it; no resp issued; pending requests re-arbitrated after release.
- Latency: request seen in IDLE at edge N → pmem_read/write high from cycle N+1; resp one cycle after the edge accepting the 4th pmem_resp. Minimum 6 cycles request-to-resp with a zero-wait memory (1 grant + 4 beats + 1 DONE).
- pmem_addr, pmem_read, pmem_write stable from grant through 4th beat; drop in DONE.
- Back-to-back pmem_resp on consecutive cycles supported.

## Structure
- Shared package arbiter_types: arb_state_t enum, BEATS constant, line_t (LINE_WIDTH) and burst_t (BURST_WIDTH) typedefs; imported by the cache top level.
- Sub-module line_burst_buffer: 256-bit buffer with parallel load, beat-indexed write on pmem_resp and beat-indexed read mux; FSM, counter and round-robin pointer stay in cacheline_arbiter.

## Test plan
- i_read only, addr 0x0000_0064, beats 0x11..,0x22..,0x33..,0x44.. → pmem_addr 0x0000_0060, i_rdata = {44..,33..,22..,11..}, i_resp one pulse, d_resp 0.
- d_write only, d_wdata beats A,B,C,D → pmem_wdata A,B,C,D in order on successive pmem_resp; pmem_write held 4 beats; d_resp one pulse.
- i_read and d_read asserted same cycle after reset → D served first, then I; both held again → D, I alternate.
- d_read and d_write both high → write burst issued, pmem_read never asserted.
- rst low during beat 2 of I_RD → pmem_read 0 same cycle, no i_resp; after release with i_read held → full fresh 4-beat read from beat 0.
- Stalled memory (pmem_resp 3 idle cycles between beats) → pmem_addr constant throughout, resp only after 4th beat.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter: widths, line/beat types and FSM states.
package arbiter_types;

    localparam int unsigned LINE_WIDTH  = 256;
    localparam int unsigned BURST_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned BEAT_IDX_W  = $clog2(BEATS);
    localparam int unsigned OFFSET_W    = $clog2(LINE_WIDTH / 8);

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [BURST_WIDTH-1:0] burst_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    typedef enum logic [2:0] {
        StIdle,
        StIRd,
        StDRd,
        StDWr,
        StDone
    } arb_state_t;

    function automatic addr_t line_align(addr_t addr);
        return {addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Cache-side and memory-side signals of the cacheline arbiter; master is the arbiter itself.
interface cacheline_arbiter_if;
    import arbiter_types::*;

    logic   i_read;
    addr_t  i_addr;
    line_t  i_rdata;
    logic   i_resp;

    logic   d_read;
    logic   d_write;
    addr_t  d_addr;
    line_t  d_wdata;
    line_t  d_rdata;
    logic   d_resp;

    logic   pmem_read;
    logic   pmem_write;
    addr_t  pmem_addr;
    burst_t pmem_wdata;
    burst_t pmem_rdata;
    logic   pmem_resp;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

endinterface

// File: rtl/cacheline_arbiter_line_burst_buffer.sv
// Line buffer: parallel load of a write-back line, beat-indexed fill from memory, beat read mux.
module line_burst_buffer
    import arbiter_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  line_t                 load_line,
    input  logic                  beat_we,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    input  burst_t                beat_wdata,
    output line_t                 line,
    output burst_t                beat_rdata
);

    line_t line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (beat_we) begin
            line_q[beat_idx*BURST_WIDTH +: BURST_WIDTH] <= beat_wdata;
        end
    end

    assign line       = line_q;
    assign beat_rdata = line_q[beat_idx*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I- and D-cache; each line
// transfer is split into BEATS memory beats.
module cacheline_arbiter
    import arbiter_types::*;
(
    input  logic                clk,
    input  logic                rst,
    cacheline_arbiter_if.master bus
);

    arb_state_t            state_q;
    logic [BEAT_IDX_W-1:0] cnt_q;
    logic                  prio_d_q;  // 1: D-cache wins the next contended grant
    logic                  gnt_d_q;
    addr_t                 addr_q;

    logic   d_req;
    logic   d_wins;
    logic   busy_rd;
    logic   beat_we;
    logic   load;
    logic   last_beat;
    line_t  line;
    burst_t beat_rdata;

    assign d_req     = bus.d_read | bus.d_write;
    assign d_wins    = d_req & (prio_d_q | ~bus.i_read);
    assign busy_rd   = (state_q == StIRd) || (state_q == StDRd);
    assign beat_we   = busy_rd & bus.pmem_resp;
    assign load      = (state_q == StIdle) & d_wins & bus.d_write;
    assign last_beat = (cnt_q == BEAT_IDX_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prio_d_q <= 1'b1;
            gnt_d_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_read | d_req) begin
                        cnt_q    <= '0;
                        gnt_d_q  <= d_wins;
                        prio_d_q <= ~d_wins;
                        if (d_wins) begin
                            addr_q  <= line_align(bus.d_addr);
                            // Write-back takes precedence over a simultaneous D-side read.
                            state_q <= bus.d_write ? StDWr : StDRd;
                        end else begin
                            addr_q  <= line_align(bus.i_addr);
                            state_q <= StIRd;
                        end
                    end
                end
                StIRd, StDRd, StDWr: begin
                    if (bus.pmem_resp) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    line_burst_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_line  (bus.d_wdata),
        .beat_we    (beat_we),
        .beat_idx   (cnt_q),
        .beat_wdata (bus.pmem_rdata),
        .line       (line),
        .beat_rdata (beat_rdata)
    );

    assign bus.pmem_read  = busy_rd;
    assign bus.pmem_write = (state_q == StDWr);
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = beat_rdata;
    assign bus.i_resp     = (state_q == StDone) & ~gnt_d_q;
    assign bus.d_resp     = (state_q == StDone) & gnt_d_q;
    assign bus.i_rdata    = line;
    assign bus.d_rdata    = line;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter with a latency-configurable burst memory model.
module tb_cacheline_arbiter;
    import arbiter_types::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_if bus ();

    cacheline_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic  is_d;
        addr_t addr;
        line_t data;
    } exp_t;

    exp_t   exp_q[$];
    burst_t exp_w_q[$];
    burst_t wlog_q[$];
    addr_t  log_addr_q[$];
    burst_t rd_beats[4];

    int mem_gap = 0;
    int addr_changed = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int beats_total = 0;
    int i_resp_cnt = 0;
    int d_resp_cnt = 0;
    int errors = 0;
    int checks = 0;

    // Burst memory: responds after mem_gap idle cycles per beat, logs addresses and write beats.
    initial begin : mem_model
        int    k;
        int    wait_cnt;
        logic  in_txn;
        addr_t txn_addr;
        k = 0;
        wait_cnt = 0;
        in_txn = 1'b0;
        txn_addr = '0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!rst) begin
                k = 0;
                wait_cnt = 0;
                in_txn = 1'b0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    txn_addr = bus.pmem_addr;
                    log_addr_q.push_back(bus.pmem_addr);
                end
                if (bus.pmem_addr !== txn_addr) addr_changed++;
                if (bus.pmem_read) rd_cycles++;
                else wr_cycles++;
                if (wait_cnt < mem_gap) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    bus.pmem_resp = 1'b1;
                    beats_total++;
                    if (bus.pmem_read) bus.pmem_rdata = rd_beats[k];
                    else wlog_q.push_back(bus.pmem_wdata);
                    k = (k == 3) ? 0 : k + 1;
                    if (k == 0) in_txn = 1'b0;
                end
            end
        end
    end

    initial begin : resp_counter
        forever begin
            @(negedge clk);
            if (bus.i_resp === 1'b1) i_resp_cnt++;
            if (bus.d_resp === 1'b1) d_resp_cnt++;
        end
    end

    task automatic reset_dut();
        rst = 1'b0;
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        log_addr_q.delete();
        wlog_q.delete();
        exp_w_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_pmem_rw: got %b%b want 00", bus.pmem_read, bus.pmem_write);
        end
        checks++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got %b%b want 00", bus.i_resp, bus.d_resp);
        end
        checks++;
        if (bus.pmem_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", bus.pmem_addr);
        end
        checks++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", bus.i_rdata);
        end
        checks++;
        if (bus.pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h want 0", bus.pmem_wdata);
        end
        reset_dut();
    endtask

    task automatic test_i_read();
        exp_t e;
        int   n;
        logic got;
        int   d0;
        rd_beats[0] = 64'h1111_1111_1111_1111;
        rd_beats[1] = 64'h2222_2222_2222_2222;
        rd_beats[2] = 64'h3333_3333_3333_3333;
        rd_beats[3] = 64'h4444_4444_4444_4444;
        mem_gap = 0;
        e.is_d = 1'b0;
        e.addr = 32'h0000_0060;
        e.data = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        exp_q.push_back(e);
        d0 = d_resp_cnt;
        bus.i_addr = 32'h0000_0064;
        bus.i_read = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = bus.i_resp | bus.d_resp;
        end
        bus.i_read = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL i_read_timeout: got no resp want resp");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin
                errors++;
                $display("FAIL i_read_side: got i=%b d=%b want i=1 d=0", bus.i_resp, bus.d_resp);
            end
            checks++;
            if (bus.i_rdata !== e.data) begin
                errors++;
                $display("FAIL i_read_data: got %h want %h", bus.i_rdata, e.data);
            end
            checks++;
            if (n !== 5) begin
                errors++;
                $display("FAIL i_read_latency: got %0d want 5", n);
            end
            checks++;
            if (log_addr_q.size() == 0 || log_addr_q[0] !== e.addr) begin
                errors++;
                $display("FAIL i_read_addr: got %h want %h",
                         (log_addr_q.size() == 0) ? 32'hx : log_addr_q[0], e.addr);
            end
            log_addr_q.delete();
            @(negedge clk);
            checks++;
            if (bus.i_resp !== 1'b0) begin
                errors++;
                $display("FAIL i_read_pulse: got %b want 0", bus.i_resp);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (d_resp_cnt !== d0) begin
            errors++;
            $display("FAIL i_read_no_dresp: got %0d want %0d", d_resp_cnt, d0);
        end
    endtask

    // Shared body for plain write-back and for d_read+d_write (write must win).
    task automatic run_write(input string name, input logic with_read);
        int   n;
        logic got;
        int   rd0;
        int   wr0;
        exp_w_q.push_back(64'hAAAA_0000_AAAA_0001);
        exp_w_q.push_back(64'hBBBB_0000_BBBB_0002);
        exp_w_q.push_back(64'hCCCC_0000_CCCC_0003);
        exp_w_q.push_back(64'hDDDD_0000_DDDD_0004);
        bus.d_wdata = {exp_w_q[3], exp_w_q[2], exp_w_q[1], exp_w_q[0]};
        bus.d_addr = 32'h0000_2A3F;
        wlog_q.delete();
        log_addr_q.delete();
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        mem_gap = 0;
        bus.d_write = 1'b1;
        bus.d_read = with_read;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = bus.i_resp | bus.d_resp;
        end
        bus.d_write = 1'b0;
        bus.d_read = 1'b0;
        checks++;
        if (!got || bus.d_resp !== 1'b1) begin
            errors++;
            $display("FAIL %s_dresp: got d=%b want 1", name, bus.d_resp);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (wlog_q.size() == 0 || wlog_q[0] !== exp_w_q[0]) begin
                errors++;
                $display("FAIL %s_wbeat%0d: got %h want %h", name, b,
                         (wlog_q.size() == 0) ? 64'hx : wlog_q[0], exp_w_q[0]);
            end
            if (wlog_q.size() != 0) void'(wlog_q.pop_front());
            void'(exp_w_q.pop_front());
        end
        checks++;
        if (wr_cycles - wr0 !== 4) begin
            errors++;
            $display("FAIL %s_write_held: got %0d want 4", name, wr_cycles - wr0);
        end
        checks++;
        if (rd_cycles - rd0 !== 0) begin
            errors++;
            $display("FAIL %s_no_read: got %0d want 0", name, rd_cycles - rd0);
        end
        checks++;
        if (log_addr_q.size() == 0 || log_addr_q[0] !== 32'h0000_2A20) begin
            errors++;
            $display("FAIL %s_addr: got %h want 00002a20", name,
                     (log_addr_q.size() == 0) ? 32'hx : log_addr_q[0]);
        end
        @(negedge clk);
        checks++;
        if (bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: got %b want 0", name, bus.d_resp);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_d_write();
        run_write("d_write", 1'b0);
    endtask

    task automatic test_read_write_both();
        run_write("rw_both", 1'b1);
    endtask

    task automatic test_contention();
        exp_t e;
        int   n;
        logic got;
        reset_dut();
        rd_beats[0] = 64'h0123_4567_89AB_CDEF;
        rd_beats[1] = 64'hFEDC_BA98_7654_3210;
        rd_beats[2] = 64'h5A5A_5A5A_A5A5_A5A5;
        rd_beats[3] = 64'h0F0F_F0F0_0F0F_F0F0;
        mem_gap = 0;
        for (int t = 0; t < 4; t++) begin
            e.is_d = (t % 2 == 0);
            e.addr = e.is_d ? 32'h0000_0200 : 32'h0000_0100;
            e.data = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
            exp_q.push_back(e);
        end
        bus.i_addr = 32'h0000_0104;
        bus.d_addr = 32'h0000_021C;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                got = bus.i_resp | bus.d_resp;
            end
            if (t == 3) begin
                bus.i_read = 1'b0;
                bus.d_read = 1'b0;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL contention_timeout%0d: got no resp want resp", t);
                break;
            end
            e = exp_q.pop_front();
            checks++;
            if ({bus.d_resp, bus.i_resp} !== (e.is_d ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_order%0d: got d=%b i=%b want d=%b", t,
                         bus.d_resp, bus.i_resp, e.is_d);
            end
            checks++;
            if ((e.is_d ? bus.d_rdata : bus.i_rdata) !== e.data) begin
                errors++;
                $display("FAIL contention_data%0d: got %h want %h", t,
                         e.is_d ? bus.d_rdata : bus.i_rdata, e.data);
            end
            checks++;
            if (log_addr_q.size() == 0 || log_addr_q[0] !== e.addr) begin
                errors++;
                $display("FAIL contention_addr%0d: got %h want %h", t,
                         (log_addr_q.size() == 0) ? 32'hx : log_addr_q[0], e.addr);
            end
            if (log_addr_q.size() != 0) void'(log_addr_q.pop_front());
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   n;
        logic got;
        int   i0;
        int   b0;
        line_t want;
        rd_beats[0] = 64'h1000_0000_0000_0001;
        rd_beats[1] = 64'h2000_0000_0000_0002;
        rd_beats[2] = 64'h3000_0000_0000_0003;
        rd_beats[3] = 64'h4000_0000_0000_0004;
        want = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
        mem_gap = 0;
        i0 = i_resp_cnt;
        bus.i_addr = 32'h0000_0410;
        bus.i_read = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.i_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: got rd=%b resp=%b want 00", bus.pmem_read, bus.i_resp);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        log_addr_q.delete();
        b0 = beats_total;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = bus.i_resp | bus.d_resp;
        end
        bus.i_read = 1'b0;
        checks++;
        if (!got || bus.i_resp !== 1'b1 || bus.i_rdata !== want) begin
            errors++;
            $display("FAIL reset_mid_data: got resp=%b %h want 1 %h", bus.i_resp, bus.i_rdata, want);
        end
        checks++;
        if (beats_total - b0 !== 4) begin
            errors++;
            $display("FAIL reset_mid_beats: got %0d want 4", beats_total - b0);
        end
        checks++;
        if (log_addr_q.size() == 0 || log_addr_q[0] !== 32'h0000_0400) begin
            errors++;
            $display("FAIL reset_mid_addr: got %h want 00000400",
                     (log_addr_q.size() == 0) ? 32'hx : log_addr_q[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (i_resp_cnt - i0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_resp_count: got %0d want 1", i_resp_cnt - i0);
        end
    endtask

    task automatic test_stall();
        int    n;
        logic  got;
        int    b0;
        line_t want;
        rd_beats[0] = 64'hCAFE_0000_0000_0010;
        rd_beats[1] = 64'hCAFE_0000_0000_0020;
        rd_beats[2] = 64'hCAFE_0000_0000_0030;
        rd_beats[3] = 64'hCAFE_0000_0000_0040;
        want = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
        mem_gap = 3;
        addr_changed = 0;
        log_addr_q.delete();
        b0 = beats_total;
        bus.d_addr = 32'h1234_5678;
        bus.d_read = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = bus.i_resp | bus.d_resp;
        end
        bus.d_read = 1'b0;
        checks++;
        if (!got || bus.d_resp !== 1'b1 || bus.d_rdata !== want) begin
            errors++;
            $display("FAIL stall_data: got resp=%b %h want 1 %h", bus.d_resp, bus.d_rdata, want);
        end
        checks++;
        if (beats_total - b0 !== 4) begin
            errors++;
            $display("FAIL stall_beats_before_resp: got %0d want 4", beats_total - b0);
        end
        checks++;
        if (addr_changed !== 0) begin
            errors++;
            $display("FAIL stall_addr_stable: got %0d changes want 0", addr_changed);
        end
        checks++;
        if (log_addr_q.size() == 0 || log_addr_q[0] !== 32'h1234_5660) begin
            errors++;
            $display("FAIL stall_addr: got %h want 12345660",
                     (log_addr_q.size() == 0) ? 32'hx : log_addr_q[0]);
        end
        mem_gap = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_read = 1'b0;
        bus.i_addr = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        test_reset();
        test_contention();
        test_i_read();
        test_d_write();
        test_read_write_both();
        test_reset_mid();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
